mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 57 +++++
 rtl/mem_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the instruction/data cache memory arbiter: bus widths,
// line/address types, the arbiter state encoding and the port-select type
// used to remember which cache was granted last.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses around the arbiter:
//   instruction cache : i_read, i_address -> i_resp, i_rdata
//   data cache        : d_read, d_write, d_address, d_wdata -> d_resp, d_rdata
//   physical memory   : mem_read, mem_write, mem_address, mem_wdata
//                       <- mem_resp, mem_rdata
// Modports:
//   slave  - the arbiter: serves both caches and forwards to memory.
//   master - the environment: the two caches plus the memory.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Instruction cache
  logic  i_read;
  addr_t i_address;
  logic  i_resp;
  line_t i_rdata;

  // Data cache
  logic  d_read;
  logic  d_write;
  addr_t d_address;
  line_t d_wdata;
  logic  d_resp;
  line_t d_rdata;

  // Physical memory
  logic  mem_read;
  logic  mem_write;
  addr_t mem_address;
  line_t mem_wdata;
  logic  mem_resp;
  line_t mem_rdata;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata,
    input  mem_resp, mem_rdata,
    output i_resp, i_rdata,
    output d_resp, d_rdata,
    output mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata,
    output mem_resp, mem_rdata,
    input  i_resp, i_rdata,
    input  d_resp, d_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata
  );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one physical memory port between an instruction cache and a data
// cache. At most one transaction is in flight. Ties are broken in favour of
// the port not served last, so two continuously requesting caches alternate.
// Every transaction is followed by at least one IDLE cycle with no memory
// request.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - mem_arbiter_if.slave (cache and memory buses)
//
// Only the state and the last-served port are registered. While a port is
// being served its request lines are forwarded to memory combinationally and
// mem_resp is reflected back as the completion pulse in the same cycle, so a
// requester that drops its lines mid-service drops the memory request with it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_t r_state;
  port_t  r_last_served;
  logic   w_d_req;

  assign w_d_req = bus.d_read | bus.d_write;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last_served <= PORT_D;   // first tie after reset goes to I
    end else begin
      case (r_state)
        IDLE: begin
          // I wins when it is alone, or on a tie when D was served last.
          if (bus.i_read && (!w_d_req || r_last_served == PORT_D)) begin
            r_state       <= SERVE_I;
            r_last_served <= PORT_I;
          end else if (w_d_req) begin
            r_state       <= SERVE_D;
            r_last_served <= PORT_D;
          end
          // mem_resp arriving here belongs to an abandoned transaction.
        end
        SERVE_I, SERVE_D: begin
          // Held until memory completes, whatever the requester does.
          if (bus.mem_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    bus.i_resp      = 1'b0;
    bus.d_resp      = 1'b0;
    case (r_state)
      SERVE_I: begin
        bus.mem_read    = bus.i_read;
        bus.mem_address = bus.i_address;
        bus.i_resp      = bus.mem_resp;
      end
      SERVE_D: begin
        bus.mem_read    = bus.d_read;
        bus.mem_write   = bus.d_write;
        bus.mem_address = bus.d_address;
        bus.mem_wdata   = bus.d_wdata;
        bus.d_resp      = bus.mem_resp;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; the resp pulse tells each cache when it is valid.
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule : mem_arbiter
